// File: rtl/regbank_sb.sv
// Register bank with two bypassed combinational read ports, one clocked write port
// and a per-register pending scoreboard that stalls issue on unresolved sources.
module regbank_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              comp_sig,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] rd_issue,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     cnt_d;

  logic [DATA_W-1:0] a_raw, b_raw;
  logic pend_rs, pend_rt, pend_rd, pend_wr;
  logic wr_ok, set_ok, src_pend_rs, src_pend_rt, inc, dec;

  // Register 0 (when hardwired) and addresses past NUM_REGS hold no state.
  function automatic logic writable(input logic [ADDR_W-1:0] x);
    return (int'(x) < NUM_REGS) && !((ZERO_REG != 0) && (x == '0));
  endfunction

  always_comb begin
    a_raw   = '0;
    b_raw   = '0;
    pend_rs = 1'b0;
    pend_rt = 1'b0;
    pend_rd = 1'b0;
    pend_wr = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rs == ADDR_W'(i)) begin
        a_raw   = regs_q[i];
        pend_rs = pend_q[i];
      end
      if (rt == ADDR_W'(i)) begin
        b_raw   = regs_q[i];
        pend_rt = pend_q[i];
      end
      if (rd_issue == ADDR_W'(i)) pend_rd = pend_q[i];
      if (wr_addr == ADDR_W'(i))  pend_wr = pend_q[i];
    end
  end

  always_comb begin
    wr_ok = wr_en && writable(wr_addr);

    a = '0;
    if (writable(rs)) a = (wr_ok && wr_addr == rs) ? wr_data : a_raw;
    b = '0;
    if (writable(rt)) b = (wr_ok && wr_addr == rt) ? wr_data : b_raw;
    comp_sig = (a == b);

    // A source being written back this cycle is already available via bypass.
    src_pend_rs = writable(rs) && pend_rs && !(wr_en && wr_addr == rs);
    src_pend_rt = writable(rt) && pend_rt && !(wr_en && wr_addr == rt);
    stall       = issue_en && (src_pend_rs || src_pend_rt);

    set_ok = issue_en && !stall && writable(rd_issue);
    inc    = set_ok && !pend_rd;
    dec    = wr_ok && pend_wr && !(set_ok && rd_issue == wr_addr);
    cnt_d  = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);

    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      pend_d[i] = pend_q[i];
      if (wr_ok && wr_addr == ADDR_W'(i)) begin
        regs_d[i] = wr_data;
        pend_d[i] = 1'b0;
      end
      // A new producer issued alongside the writeback keeps the register pending.
      if (set_ok && rd_issue == ADDR_W'(i)) pend_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_regbank_sb.sv
// Bench for regbank_sb (16 implemented regs, reg 0 hardwired): directed vector
// table, asynchronous reset sequence, then random traffic against a reference model.
module tb_regbank_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 16;

  logic          clk, rst;
  logic [AW-1:0] rs, rt, rd_issue, wr_addr;
  logic [DW-1:0] a, b, wr_data;
  logic          comp_sig, issue_en, wr_en, stall;
  logic [AW:0]   pend_cnt;

  regbank_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .a(a), .b(b), .comp_sig(comp_sig),
    .issue_en(issue_en), .rd_issue(rd_issue), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .stall(stall), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input int r_s, input int r_t, input bit ie, input int rd,
                       input bit we, input int wa, input logic [DW-1:0] wd);
    rs = AW'(r_s); rt = AW'(r_t); issue_en = ie; rd_issue = AW'(rd);
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
  endtask

  typedef struct {
    int rs; int rt; bit ie; int rd; bit we; int wa; logic [DW-1:0] wd;
    logic [DW-1:0] exp_a; logic [DW-1:0] exp_b; bit exp_comp; bit exp_stall; int exp_cnt;
  } vec_t;
  vec_t vq[$];

  // Reference model: plain arrays, whole-bank popcount for the pending count.
  logic [DW-1:0] mreg [32];
  bit            mpend[32];

  function automatic bit m_writable(int x);
    return x < NR && x != 0;
  endfunction
  function automatic logic [DW-1:0] m_read(int x);
    if (!m_writable(x)) return '0;
    if (wr_en && int'(wr_addr) == x) return wr_data;
    return mreg[x];
  endfunction
  function automatic bit m_src_pend(int x);
    return mpend[x] && !(wr_en && int'(wr_addr) == x);
  endfunction
  function automatic bit m_stall();
    return issue_en && (m_src_pend(int'(rs)) || m_src_pend(int'(rt)));
  endfunction
  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mpend[i]);
    return n;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin mreg[i] = '0; mpend[i] = 1'b0; end
  endtask
  task automatic m_edge();
    bit st;
    st = m_stall();
    if (wr_en && m_writable(int'(wr_addr))) begin
      mreg[wr_addr]  = wr_data;
      mpend[wr_addr] = 1'b0;
    end
    if (issue_en && !st && m_writable(int'(rd_issue))) mpend[rd_issue] = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive(3, 3, 0, 0, 0, 0, '0);
    #3;
    check("reset_a", a, 0);
    check("reset_b", b, 0);
    check("reset_comp", comp_sig, 1);
    check("reset_stall", stall, 0);
    check("reset_cnt", pend_cnt, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    //            rs  rt ie rd we wa  wd            a             b            cmp st cnt
    vq.push_back('{3,  3, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 0});
    vq.push_back('{5,  0, 0, 0, 1, 5, 32'hAA,       32'hAA,       32'h0,        0, 0, 0});
    vq.push_back('{5,  5, 0, 0, 0, 0, 32'h0,        32'hAA,       32'hAA,       1, 0, 0});
    vq.push_back('{1,  2, 1, 7, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 0});
    vq.push_back('{7,  0, 1, 8, 0, 0, 32'h0,        32'h0,        32'h0,        1, 1, 1});
    vq.push_back('{7,  0, 1, 8, 1, 7, 32'h1234,     32'h1234,     32'h0,        0, 0, 1});
    vq.push_back('{7,  8, 0, 0, 0, 0, 32'h0,        32'h1234,     32'h0,        0, 0, 1});
    vq.push_back('{9,  0, 1, 9, 1, 9, 32'h99,       32'h99,       32'h0,        0, 0, 1});
    vq.push_back('{0,  0, 1, 9, 1, 9, 32'h55,       32'h0,        32'h0,        1, 0, 2});
    vq.push_back('{9,  9, 0, 0, 0, 0, 32'h0,        32'h55,       32'h55,       1, 0, 2});
    vq.push_back('{9,  0, 1, 10,0, 0, 32'h0,        32'h55,       32'h0,        0, 1, 2});
    vq.push_back('{0,  0, 1, 0, 1, 0, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 0, 2});
    vq.push_back('{20, 5, 0, 0, 1, 20,32'hDEAD,     32'h0,        32'hAA,       0, 0, 2});
    vq.push_back('{20, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 2});
    vq.push_back('{8,  9, 0, 0, 1, 8, 32'h77,       32'h77,       32'h55,       0, 0, 2});
    vq.push_back('{8,  8, 0, 0, 0, 0, 32'h0,        32'h77,       32'h77,       1, 0, 1});

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].rs, vq[k].rt, vq[k].ie, vq[k].rd, vq[k].we, vq[k].wa, vq[k].wd);
      @(negedge clk);
      check($sformatf("v%0d_a", k), a, vq[k].exp_a);
      check($sformatf("v%0d_b", k), b, vq[k].exp_b);
      check($sformatf("v%0d_comp", k), comp_sig, vq[k].exp_comp);
      check($sformatf("v%0d_stall", k), stall, vq[k].exp_stall);
      check($sformatf("v%0d_cnt", k), pend_cnt, vq[k].exp_cnt);
      @(posedge clk); #1;
    end

    // Build up pending state, then drop reset between edges.
    drive(0, 0, 0, 0, 1, 1, 32'h11); @(posedge clk); #1;
    drive(0, 0, 1, 1, 0, 0, '0);     @(posedge clk); #1;
    drive(0, 0, 1, 2, 0, 0, '0);     @(posedge clk); #1;
    drive(0, 0, 1, 3, 0, 0, '0);     @(posedge clk); #1;
    drive(1, 2, 1, 4, 0, 0, '0);     #1;
    check("pre_rst_stall", stall, 1);
    check("pre_rst_cnt", pend_cnt, 4);
    check("pre_rst_a", a, 32'h11);
    rst = 1'b0; #1;
    check("async_rst_cnt", pend_cnt, 0);
    check("async_rst_a", a, 0);
    check("async_rst_b", b, 0);
    check("async_rst_comp", comp_sig, 1);
    check("async_rst_stall", stall, 0);
    @(negedge clk); rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, '0);
    @(posedge clk); #1;
    m_reset();

    for (int n = 0; n < 600; n++) begin
      int wa;
      wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 19) : $urandom_range(1, 6);
      drive($urandom_range(0, 19) % 8 == 0 ? $urandom_range(0, 19) : $urandom_range(0, 7),
            $urandom_range(0, 7), bit'($urandom_range(0, 1)), $urandom_range(0, 9),
            ($urandom_range(0, 2) == 0), wa, $urandom);
      if ($urandom_range(0, 5) == 0) wr_addr = rs;
      @(negedge clk);
      check($sformatf("r%0d_a", n), a, m_read(int'(rs)));
      check($sformatf("r%0d_b", n), b, m_read(int'(rt)));
      check($sformatf("r%0d_comp", n), comp_sig, m_read(int'(rs)) == m_read(int'(rt)));
      check($sformatf("r%0d_stall", n), stall, m_stall());
      check($sformatf("r%0d_cnt", n), pend_cnt, m_count());
      @(posedge clk);
      m_edge();
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
